// File: rtl/spi_slave_maquinaestats_mlf.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_maquinaestats_mlf
// Purpose  : SPI slave, all four SPI modes, full duplex, MSB first. The SPI
//            pins are oversampled by i_clk through 2-flop synchronizers.
//            A single-entry TX holding register feeds MISO. Each received
//            byte is presented on o_RX_Byte with a one-cycle o_RX_DV strobe.
// Ports    : i_clk, i_rst       system clock, synchronous active-high reset
//            i_TX_Byte/i_TX_DV  write into the TX holding register
//            o_TX_Ready         holding register empty
//            o_TX_Underrun      a byte started with nothing to send (0x00 sent)
//            o_RX_DV/o_RX_Byte  received byte strobe and value
//            o_RX_count         bytes completed in this CS frame (saturates at 7)
//            i_SPI_*            asynchronous master pins
//            o_SPI_MISO(_en)    serial out and its tristate enable
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_maquinaestats_mlf #(
   parameter int SPI_MODE         = 0,
   parameter int MAX_BYTES_PER_CS = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic       o_TX_Underrun,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic [2:0] o_RX_count,
   input  logic       i_SPI_clk,
   input  logic       i_SPI_CS_n,
   input  logic       i_SPI_MOSI,
   output logic       o_SPI_MISO,
   output logic       o_SPI_MISO_en
);

   localparam logic CPOL        = ((SPI_MODE / 2) % 2) == 1;
   localparam logic CPHA        = (SPI_MODE % 2) == 1;
   // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling.
   localparam logic SAMPLE_RISE = (CPOL == CPHA);

   generate
      if (SPI_MODE < 0 || SPI_MODE > 3 || MAX_BYTES_PER_CS < 1) begin : g_bad_param
         $error("spi_slave_maquinaestats_mlf: illegal SPI_MODE or MAX_BYTES_PER_CS");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;

   state_t     state_q, state_d;
   logic [1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d, mosi_sync_q, mosi_sync_d;
   logic       cs_prev_q, cs_prev_d, sck_prev_q, sck_prev_d;
   logic [1:0] settle_q, settle_d;
   logic       armed_q, armed_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       load_pend_q, load_pend_d;
   logic       commit_pend_q, commit_pend_d;
   logic       peek_full_q, peek_full_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic       underrun_q, underrun_d;
   logic       rx_dv_q, rx_dv_d;
   logic [7:0] rx_byte_q, rx_byte_d;
   logic [2:0] rx_count_q, rx_count_d;
   logic       miso_q, miso_d;
   logic       miso_en_q, miso_en_d;

   logic       w_cs_s, w_sck_s, w_mosi_s;
   logic       w_sample, w_shift, w_cs_fall, w_take;
   logic [7:0] w_next_tx;

   assign w_cs_s    = cs_sync_q[1];
   assign w_sck_s   = sck_sync_q[1];
   assign w_mosi_s  = mosi_sync_q[1];
   assign w_sample  = SAMPLE_RISE ? (w_sck_s & ~sck_prev_q) : (~w_sck_s & sck_prev_q);
   assign w_shift   = SAMPLE_RISE ? (~w_sck_s & sck_prev_q) : (w_sck_s & ~sck_prev_q);
   // The synchronizers come out of reset at idle levels, so a CS_n that is
   // already low when reset releases must not look like a new frame: the
   // block only arms after it has really observed CS_n high.
   assign w_cs_fall = armed_q & cs_prev_q & ~w_cs_s;
   assign w_next_tx = hold_full_q ? hold_q : 8'h00;

   always_comb begin
      cs_sync_d     = {cs_sync_q[0], i_SPI_CS_n};
      sck_sync_d    = {sck_sync_q[0], i_SPI_clk};
      mosi_sync_d   = {mosi_sync_q[0], i_SPI_MOSI};
      cs_prev_d     = w_cs_s;
      sck_prev_d    = w_sck_s;
      settle_d      = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      armed_d       = armed_q | ((settle_q == 2'd3) & w_cs_s);
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      load_pend_d   = load_pend_q;
      commit_pend_d = commit_pend_q;
      peek_full_d   = peek_full_q;
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      rx_byte_d     = rx_byte_q;
      rx_count_d    = rx_count_q;
      underrun_d    = 1'b0;
      rx_dv_d       = 1'b0;
      w_take        = 1'b0;

      if (w_cs_s) begin
         // CS_n high: abandon any partial byte; holding register is untouched.
         state_d       = IDLE;
         bit_cnt_d     = 3'd0;
         load_pend_d   = 1'b0;
         commit_pend_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_cs_fall) state_d = LOAD;
            end
            LOAD: begin
               bit_cnt_d   = 3'd0;
               rx_count_d  = 3'd0;
               load_pend_d = 1'b1;
               if (!CPHA) begin
                  tx_shift_d  = w_next_tx;
                  w_take      = hold_full_q;
                  underrun_d  = ~hold_full_q;
                  load_pend_d = 1'b0;
               end else begin
                  tx_shift_d  = 8'h00;
               end
               state_d = SHIFT;
            end
            SHIFT: begin
               if (w_sample) begin
                  rx_shift_d = {rx_shift_q[5:0], w_mosi_s};
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_byte_d   = {rx_shift_q, w_mosi_s};
                     rx_dv_d     = 1'b1;
                     rx_count_d  = (rx_count_q == 3'd7) ? 3'd7 : rx_count_q + 3'd1;
                     load_pend_d = 1'b1;
                  end
                  // A byte loaded early on the trailing edge only counts as
                  // started once its first sample edge arrives; this keeps the
                  // trailing edge that closes the last byte of a frame from
                  // consuming data or flagging an underrun.
                  if (commit_pend_q) begin
                     w_take        = peek_full_q;
                     underrun_d    = ~peek_full_q;
                     commit_pend_d = 1'b0;
                  end
               end else if (w_shift) begin
                  if (load_pend_q) begin
                     tx_shift_d  = w_next_tx;
                     load_pend_d = 1'b0;
                     if (CPHA) begin
                        w_take     = hold_full_q;
                        underrun_d = ~hold_full_q;
                     end else begin
                        commit_pend_d = 1'b1;
                        peek_full_d   = hold_full_q;
                     end
                  end else begin
                     tx_shift_d = {tx_shift_q[6:0], 1'b0};
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // A load that finds the register empty wins over a same-cycle write;
      // the written byte then waits for the following byte.
      if (w_take) begin
         hold_full_d = 1'b0;
      end else if (i_TX_DV && !hold_full_q) begin
         hold_full_d = 1'b1;
         hold_d      = i_TX_Byte;
      end

      miso_en_d = (state_d != IDLE);
      miso_d    = miso_en_d ? tx_shift_d[7] : 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= IDLE;
         cs_sync_q     <= 2'b11;
         sck_sync_q    <= {CPOL, CPOL};
         mosi_sync_q   <= 2'b00;
         cs_prev_q     <= 1'b1;
         sck_prev_q    <= CPOL;
         settle_q      <= 2'd0;
         armed_q       <= 1'b0;
         bit_cnt_q     <= 3'd0;
         rx_shift_q    <= 7'd0;
         tx_shift_q    <= 8'h00;
         load_pend_q   <= 1'b0;
         commit_pend_q <= 1'b0;
         peek_full_q   <= 1'b0;
         hold_q        <= 8'h00;
         hold_full_q   <= 1'b0;
         underrun_q    <= 1'b0;
         rx_dv_q       <= 1'b0;
         rx_byte_q     <= 8'h00;
         rx_count_q    <= 3'd0;
         miso_q        <= 1'b0;
         miso_en_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cs_sync_q     <= cs_sync_d;
         sck_sync_q    <= sck_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         cs_prev_q     <= cs_prev_d;
         sck_prev_q    <= sck_prev_d;
         settle_q      <= settle_d;
         armed_q       <= armed_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_shift_q    <= tx_shift_d;
         load_pend_q   <= load_pend_d;
         commit_pend_q <= commit_pend_d;
         peek_full_q   <= peek_full_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         underrun_q    <= underrun_d;
         rx_dv_q       <= rx_dv_d;
         rx_byte_q     <= rx_byte_d;
         rx_count_q    <= rx_count_d;
         miso_q        <= miso_d;
         miso_en_q     <= miso_en_d;
      end
   end

   assign o_TX_Ready    = ~hold_full_q;
   assign o_TX_Underrun = underrun_q;
   assign o_RX_DV       = rx_dv_q;
   assign o_RX_Byte     = rx_byte_q;
   assign o_RX_count    = rx_count_q;
   assign o_SPI_MISO    = miso_q;
   assign o_SPI_MISO_en = miso_en_q;

endmodule
`default_nettype wire
